// File: rtl/load_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit_pkg
//  Purpose  : Shared definitions for the byte-serial load unit: funct3 load
//             encodings, FSM state type, byte-count constants and small
//             decode helpers used by load_unit and load_extend.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package load_unit_pkg;

   // funct3 load encodings
   localparam logic [2:0] c_F3_LB  = 3'b000;
   localparam logic [2:0] c_F3_LH  = 3'b001;
   localparam logic [2:0] c_F3_LW  = 3'b010;
   localparam logic [2:0] c_F3_LBU = 3'b100;
   localparam logic [2:0] c_F3_LHU = 3'b101;

   // Number of bytes fetched per access width
   localparam logic [2:0] c_BYTES_B    = 3'd1;
   localparam logic [2:0] c_BYTES_H    = 3'd2;
   localparam logic [2:0] c_BYTES_W    = 3'd4;
   localparam logic [2:0] c_BYTES_NONE = 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WB    = 2'd2
   } state_e;

   // Byte count for a load type; zero marks an illegal funct3.
   function automatic logic [2:0] byte_count(input logic [2:0] funct3);
      logic [2:0] cnt;
      case (funct3)
         c_F3_LB, c_F3_LBU : cnt = c_BYTES_B;
         c_F3_LH, c_F3_LHU : cnt = c_BYTES_H;
         c_F3_LW           : cnt = c_BYTES_W;
         default           : cnt = c_BYTES_NONE;
      endcase
      return cnt;
   endfunction

   // Natural alignment check on the two low address bits.
   function automatic logic is_aligned(input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         c_F3_LH, c_F3_LHU : ok = (addr_lo[0] == 1'b0);
         c_F3_LW           : ok = (addr_lo == 2'b00);
         default           : ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_unit_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational width selection and sign/zero extension of the
//             assembled little-endian load data.
//  Ports    : funct3_i [2:0]  load type
//             data_i   [31:0] assembled bytes (byte i at bits 8i+7:8i)
//             value_o  [31:0] extended register write value
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
   import load_unit_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] data_i,
   output logic [31:0] value_o
);

   always_comb begin
      value_o = 32'd0;
      case (funct3_i)
         c_F3_LB  : value_o = {{24{data_i[7]}}, data_i[7:0]};
         c_F3_LH  : value_o = {{16{data_i[15]}}, data_i[15:0]};
         c_F3_LW  : value_o = data_i;
         c_F3_LBU : value_o = {24'd0, data_i[7:0]};
         c_F3_LHU : value_o = {16'd0, data_i[15:0]};
         default  : value_o = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Byte-serial load unit. Accepts a load request, reads 1/2/4
//             bytes one at a time from a byte-wide memory port, assembles
//             them little-endian, extends to 32 bits and writes the result
//             to the register file. Illegal or misaligned requests produce a
//             one-cycle load_error pulse instead.
//  Ports    : clk, rst            clock, asynchronous active-high reset
//             start_i/addr_i/funct3_i/rd_i   request (sampled when idle)
//             busy_o              unit occupied (FETCH and WB)
//             mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i   byte memory port
//             write_register_o/write_value_o/wr_en_o   register-file write
//             load_error_o        rejected-request pulse
//  Revision : 1.0  initial release
// ============================================================================
module load_unit
   import load_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [2:0]      funct3_i,
   input  logic [3:0]      rd_i,
   output logic            busy_o,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   input  logic            mem_ack_i,
   input  logic [7:0]      mem_rdata_i,
   output logic [3:0]      write_register_o,
   output logic [XLEN-1:0] write_value_o,
   output logic            wr_en_o,
   output logic            load_error_o
);

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              mem_req_q, mem_req_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   base_q, base_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        last_q, last_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [3:0]        rd_q, rd_d;
   logic [31:0]       buf_q, buf_d;
   logic [3:0]        wreg_q, wreg_d;
   logic [XLEN-1:0]   wval_q, wval_d;
   logic              wr_en_q, wr_en_d;
   logic              load_error_q, load_error_d;

   logic [2:0]        w_count;
   logic              w_legal;
   logic [1:0]        w_idx_inc;
   logic [31:0]       w_buf_ins;
   logic [31:0]       w_ext;

   assign w_count   = byte_count(funct3_i);
   assign w_legal   = (w_count != c_BYTES_NONE) && is_aligned(funct3_i, addr_i[1:0]);
   assign w_idx_inc = idx_q + 2'd1;

   // Buffer with the incoming byte dropped into its little-endian lane.
   // Computed separately so the extender sees the final byte on the last
   // ack without a loop through the next-state block.
   always_comb begin
      w_buf_ins = buf_q;
      w_buf_ins[{idx_q, 3'b000} +: 8] = mem_rdata_i;
   end

   load_extend u_extend (
      .funct3_i (funct3_q),
      .data_i   (w_buf_ins),
      .value_o  (w_ext)
   );

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      base_d       = base_q;
      idx_d        = idx_q;
      last_d       = last_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      buf_d        = buf_q;
      wreg_d       = wreg_q;
      wval_d       = wval_q;
      wr_en_d      = 1'b0;
      load_error_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (w_legal) begin
                  state_d    = ST_FETCH;
                  busy_d     = 1'b1;
                  mem_req_d  = 1'b1;
                  mem_addr_d = addr_i;
                  base_d     = addr_i;
                  idx_d      = 2'd0;
                  last_d     = 2'(w_count - 3'd1);
                  funct3_d   = funct3_i;
                  rd_d       = rd_i;
                  buf_d      = 32'd0;
               end else begin
                  load_error_d = 1'b1;
               end
            end
         end

         ST_FETCH: begin
            if (mem_req_q && mem_ack_i) begin
               buf_d = w_buf_ins;
               if (idx_q == last_q) begin
                  state_d   = ST_WB;
                  mem_req_d = 1'b0;
                  wreg_d    = rd_q;
                  wval_d    = w_ext;
                  // x0 is hard-wired zero, so the write is suppressed.
                  wr_en_d   = (rd_q != 4'd0);
               end else begin
                  idx_d      = w_idx_inc;
                  mem_addr_d = base_q + {{(XLEN-2){1'b0}}, w_idx_inc};
               end
            end
         end

         ST_WB: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         base_q       <= '0;
         idx_q        <= 2'd0;
         last_q       <= 2'd0;
         funct3_q     <= 3'd0;
         rd_q         <= 4'd0;
         buf_q        <= 32'd0;
         wreg_q       <= 4'd0;
         wval_q       <= '0;
         wr_en_q      <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         base_q       <= base_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         funct3_q     <= funct3_d;
         rd_q         <= rd_d;
         buf_q        <= buf_d;
         wreg_q       <= wreg_d;
         wval_q       <= wval_d;
         wr_en_q      <= wr_en_d;
         load_error_q <= load_error_d;
      end
   end

   assign busy_o           = busy_q;
   assign mem_req_o        = mem_req_q;
   assign mem_addr_o       = mem_addr_q;
   assign write_register_o = wreg_q;
   assign write_value_o    = wval_q;
   assign wr_en_o          = wr_en_q;
   assign load_error_o     = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Purpose  : Scoreboard bench for load_unit. The driver pushes the expected
//             outcome of every request; a monitor pops and compares whenever
//             the DUT reports an error, a write, or the end of a load.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_unit;

   localparam int K_ERR   = 0;
   localparam int K_LOAD  = 1;
   localparam int K_ABORT = 2;

   typedef struct {
      int          kind;
      bit          wr;
      logic [3:0]  rd;
      logic [31:0] val;
      int          n;
      logic [31:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [31:0] addr_i;
   logic [2:0]  funct3_i;
   logic [3:0]  rd_i;
   logic        busy_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [7:0]  mem_rdata_i;
   logic [3:0]  write_register_o;
   logic [31:0] write_value_o;
   logic        wr_en_o;
   logic        load_error_o;

   always #5 clk = ~clk;

   load_unit #(.XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .start_i          (start_i),
      .addr_i           (addr_i),
      .funct3_i         (funct3_i),
      .rd_i             (rd_i),
      .busy_o           (busy_o),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_ack_i        (mem_ack_i),
      .mem_rdata_i      (mem_rdata_i),
      .write_register_o (write_register_o),
      .write_value_o    (write_value_o),
      .wr_en_o          (wr_en_o),
      .load_error_o     (load_error_o)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        q[$];
   logic [7:0]  mem [bit [31:0]];
   bit          ack_always = 1'b1;
   int          ack_delay  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      bit [31:0] k;
      k = a;
      if (mem.exists(k)) return mem[k];
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   // Reference model: what a request should do, from the load rules.
   function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [3:0] r);
      exp_t    e;
      byte     sb;
      shortint sh;
      e.kind = K_LOAD; e.addr = a; e.rd = r; e.wr = (r != 4'd0); e.n = 0; e.val = 32'd0;
      case (f3)
         3'b000: begin e.n = 1; sb = byte'(mem_rd(a)); e.val = 32'(int'(sb)); end
         3'b100: begin e.n = 1; e.val = {24'd0, mem_rd(a)}; end
         3'b001, 3'b101: begin
            if (a[0]) e.kind = K_ERR;
            else begin
               e.n = 2;
               sh  = shortint'({mem_rd(a + 32'd1), mem_rd(a)});
               e.val = (f3 == 3'b001) ? 32'(int'(sh)) : {16'd0, mem_rd(a + 32'd1), mem_rd(a)};
            end
         end
         3'b010: begin
            if (a[1:0] != 2'b00) e.kind = K_ERR;
            else begin
               e.n = 4;
               e.val = {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
            end
         end
         default: e.kind = K_ERR;
      endcase
      return e;
   endfunction

   // Memory responder
   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack_i = 1'b0;
      mem_rdata_i = 8'd0;
      forever begin
         @(negedge clk);
         if (ack_always) begin
            mem_ack_i = 1'b1; mem_rdata_i = mem_rd(mem_addr_o); wcnt = 0;
         end else if (mem_req_o) begin
            if (wcnt >= ack_delay) begin
               mem_ack_i = 1'b1; mem_rdata_i = mem_rd(mem_addr_o); wcnt = 0;
            end else begin
               mem_ack_i = 1'b0; mem_rdata_i = 8'($urandom); wcnt++;
            end
         end else begin
            mem_ack_i = 1'b0; mem_rdata_i = 8'($urandom); wcnt = 0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      int   hs;
      int   wrc;
      bit   prev_busy;
      bit   has;
      exp_t f;
      hs = 0; wrc = 0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            if (q.size() > 0 && q[0].kind == K_ABORT) begin
               chk("abort_bytes", hs, 2);
               void'(q.pop_front());
            end
            hs = 0; wrc = 0; prev_busy = 1'b0;
         end else begin
            has = (q.size() > 0);
            if (has) f = q[0];
            if (busy_o) chk("mem_req_busy", mem_req_o, 32'(has && f.kind != K_ERR && hs < f.n));
            else        chk("mem_req_idle", mem_req_o, 0);
            if (mem_req_o && mem_ack_i) begin
               if (has) chk("mem_addr", mem_addr_o, f.addr + 32'(hs));
               else     chk("req_pending", 32'(has), 1);
               hs++;
            end
            if (load_error_o) begin
               chk("err_pending", 32'(has), 1);
               if (has) begin
                  chk("err_kind", K_ERR, f.kind);
                  void'(q.pop_front());
                  has = (q.size() > 0);
                  if (has) f = q[0];
               end
            end
            if (wr_en_o) begin
               chk("wr_pending", 32'(has), 1);
               if (has) begin
                  chk("wr_kind", K_LOAD, f.kind);
                  chk("wr_rd_nonzero", 32'(f.wr), 1);
                  chk("wr_register", write_register_o, f.rd);
                  chk("wr_value", write_value_o, f.val);
               end
               wrc++;
            end
            if (prev_busy && !busy_o) begin
               chk("end_pending", 32'(has), 1);
               if (has) begin
                  chk("end_kind", K_LOAD, f.kind);
                  chk("byte_count", hs, f.n);
                  chk("wr_en_count", wrc, f.wr ? 1 : 0);
                  chk("hold_register", write_register_o, f.rd);
                  chk("hold_value", write_value_o, f.val);
                  void'(q.pop_front());
               end
               hs = 0; wrc = 0;
            end
            prev_busy = busy_o;
         end
      end
   end

   // Caller must be at a falling edge; returns at the next falling edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [3:0] r, input bit abort);
      exp_t e;
      e = model(f3, a, r);
      if (abort) e.kind = K_ABORT;
      q.push_back(e);
      start_i = 1'b1; funct3_i = f3; addr_i = a; rd_i = r;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // lat = cycle (start cycle = 0) in which wr_en was seen, -1 if never.
   task automatic wait_done(output int lat);
      int cyc;
      lat = -1; cyc = 1;
      forever begin
         #1;
         if (wr_en_o && lat < 0) lat = cyc;
         if (q.size() == 0 && !busy_o) break;
         if (cyc > 300) begin
            chk("wait_timeout", q.size(), 0);
            q.delete();
            break;
         end
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_mem_req"}, mem_req_o, 0);
      chk({tag, "_mem_addr"}, mem_addr_o, 0);
      chk({tag, "_wreg"}, write_register_o, 0);
      chk({tag, "_wval"}, write_value_o, 0);
      chk({tag, "_wr_en"}, wr_en_o, 0);
      chk({tag, "_load_error"}, load_error_o, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int g;
      logic [2:0] legal_f3 [5];
      logic [2:0] f3;
      logic [31:0] a;
      legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
      legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

      rst = 1'b1; start_i = 1'b0; addr_i = 32'd0; funct3_i = 3'd0; rd_i = 4'd0;
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      mem[32'h3] = 8'h80;
      mem[32'h10] = 8'hFF; mem[32'h11] = 8'hEE;
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // LW, ack tied high
      ack_always = 1'b1;
      issue(3'b010, 32'h100, 4'd5, 1'b0);
      wait_done(lat);
      chk("lw_latency", lat, 5);
      chk("lw_value", write_value_o, 32'h12345678);

      // LB / LBU of 0x80
      issue(3'b000, 32'h3, 4'd2, 1'b0);
      wait_done(lat);
      chk("lb_latency", lat, 2);
      chk("lb_value", write_value_o, 32'hFFFFFF80);
      issue(3'b100, 32'h3, 4'd2, 1'b0);
      wait_done(lat);
      chk("lbu_value", write_value_o, 32'h00000080);

      // Rejected requests, then a start inside the error pulse
      issue(3'b001, 32'h201, 4'd1, 1'b0);
      wait_done(lat);
      chk("misaligned_no_wr", 32'(lat), 32'hFFFFFFFF);
      issue(3'b011, 32'h40, 4'd1, 1'b0);
      wait_done(lat);
      issue(3'b110, 32'h0, 4'd7, 1'b0);
      issue(3'b010, 32'h100, 4'd7, 1'b0);
      wait_done(lat);
      chk("after_err_value", write_value_o, 32'h12345678);

      // LHU with slow memory
      ack_always = 1'b0; ack_delay = 3;
      issue(3'b101, 32'h10, 4'd6, 1'b0);
      wait_done(lat);
      chk("lhu_value", write_value_o, 32'h0000EEFF);

      // LW to x0 with another start held for the whole busy window
      ack_always = 1'b1;
      issue(3'b010, 32'h20, 4'd0, 1'b0);
      start_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h3; rd_i = 4'd3;
      g = 0;
      while (busy_o && g < 50) begin
         @(negedge clk);
         g++;
      end
      start_i = 1'b0;
      wait_done(lat);
      chk("x0_no_wr", 32'(lat), 32'hFFFFFFFF);
      repeat (3) @(negedge clk);
      chk("busy_after_ignored", busy_o, 0);

      // Reset after the second byte of an LW
      issue(3'b010, 32'h100, 4'd9, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("midload_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      issue(3'b000, 32'h3, 4'd4, 1'b0);
      wait_done(lat);
      chk("post_reset_lb", write_value_o, 32'hFFFFFF80);

      // Randomized requests
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else f3 = legal_f3[$urandom_range(0, 4)];
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         ack_always = ($urandom_range(0, 2) == 0);
         ack_delay  = $urandom_range(0, 3);
         issue(f3, a, 4'($urandom_range(0, 15)), 1'b0);
         wait_done(lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
